// File: rtl/victim_wb_ctrl_pkg.sv
// Shared victim-cache types: physical address, byte type, line geometry helpers
// and the write-back drain FSM state encoding.
package victim_wb_ctrl_pkg;

  localparam int unsigned PHYS_WIDTH = 32;

  typedef logic [PHYS_WIDTH-1:0] phys_t;
  typedef logic [7:0]            uint8_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } wb_state_t;

  function automatic int unsigned line_byte_offset(input int unsigned line_width);
    return $clog2(line_width / 8);
  endfunction

  function automatic int unsigned label_width(input int unsigned line_width);
    return PHYS_WIDTH - line_byte_offset(line_width);
  endfunction

endpackage

// File: rtl/victim_wb_ctrl_if.sv
// Memory write bus (address, data and response channels) between the
// victim write-back controller (master) and the memory system (slave).
interface victim_wb_ctrl_if
  import victim_wb_ctrl_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32
);
  phys_t                  awaddr;
  uint8_t                 awlen;
  logic                   awvalid;
  logic                   awready;
  logic [BUS_WIDTH-1:0]   wdata;
  logic [BUS_WIDTH/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  modport master (
    output awaddr, awlen, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/victim_wb_ctrl.sv
// Victim cache write-back drain: pops one evicted line, writes it as a single
// burst, and exports the in-flight label so refills of that line can stall.
module victim_wb_ctrl
  import victim_wb_ctrl_pkg::*;
#(
  parameter  int unsigned LINE_WIDTH  = 256,
  parameter  int unsigned BUS_WIDTH   = 32,
  localparam int unsigned LABEL_WIDTH = label_width(LINE_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LABEL_WIDTH+LINE_WIDTH-1:0] vc_rline,
  input  logic                              vc_empty,
  output logic                              vc_pop,
  victim_wb_ctrl_if.master                  bus,
  output logic                              inflight_valid,
  output logic [LABEL_WIDTH-1:0]            inflight_label,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic                              bus_err,
  output logic [31:0]                       lines_written
);

  localparam int unsigned BEATS  = LINE_WIDTH / BUS_WIDTH;
  localparam int unsigned OFFSET = line_byte_offset(LINE_WIDTH);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  wb_state_t                          state_q, state_d;
  logic [BEATS-1:0][BUS_WIDTH-1:0]    line_q;
  logic [LABEL_WIDTH-1:0]             label_q;
  logic [BEAT_W-1:0]                  beat_q;
  logic                               w_hs;
  logic                               b_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Pop is gated by reset so the cache never loses a head line the
  // controller is not able to latch.
  always_comb begin
    state_d      = state_q;
    vc_pop       = 1'b0;
    bus.awvalid  = 1'b0;
    bus.wvalid   = 1'b0;
    bus.wlast    = 1'b0;
    bus.bready   = 1'b0;
    case (state_q)
      IDLE: begin
        vc_pop = rst & ~vc_empty;
        if (vc_pop) state_d = ADDR;
      end
      ADDR: begin
        bus.awvalid = 1'b1;
        if (bus.awready) state_d = DATA;
      end
      DATA: begin
        bus.wvalid = 1'b1;
        bus.wlast  = (beat_q == LAST_BEAT);
        if (bus.wready && bus.wlast) state_d = RESP;
      end
      RESP: begin
        bus.bready = 1'b1;
        if (bus.bvalid) begin
          vc_pop  = rst & ~vc_empty;
          state_d = vc_pop ? ADDR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w_hs = bus.wvalid & bus.wready;
  assign b_hs = bus.bvalid & bus.bready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q        <= '0;
      label_q       <= '0;
      beat_q        <= '0;
      lines_written <= '0;
      bus_err       <= 1'b0;
    end else begin
      if (vc_pop) begin
        line_q  <= vc_rline[LINE_WIDTH-1:0];
        label_q <= vc_rline[LINE_WIDTH +: LABEL_WIDTH];
        beat_q  <= '0;
      end else if (w_hs) begin
        beat_q  <= beat_q + 1'b1;
      end
      if (b_hs) begin
        lines_written <= lines_written + 32'd1;
        bus_err       <= bus_err | (bus.bresp != 2'b00);
      end
    end
  end

  assign bus.awaddr     = {label_q, {OFFSET{1'b0}}};
  assign bus.awlen      = 8'(BEATS - 1);
  assign bus.wdata      = line_q[beat_q];
  assign bus.wstrb      = '1;
  assign inflight_valid = (state_q != IDLE);
  assign inflight_label = label_q;
  assign flush_done     = rst & flush_req & (state_q == IDLE) & vc_empty;

endmodule

// File: tb/tb_victim_wb_ctrl.sv
// Randomized bench for victim_wb_ctrl against a transaction-level model of
// the victim FIFO, the burst sequence and the response bookkeeping.
`timescale 1ns/1ps
module tb_victim_wb_ctrl;
  import victim_wb_ctrl_pkg::*;

  localparam int unsigned LINE_WIDTH  = 256;
  localparam int unsigned BUS_WIDTH   = 32;
  localparam int unsigned BEATS       = LINE_WIDTH / BUS_WIDTH;
  localparam int unsigned LABEL_WIDTH = 27;

  typedef logic [LABEL_WIDTH+LINE_WIDTH-1:0] rline_t;

  logic                   clk;
  logic                   rst;
  rline_t                 vc_rline;
  logic                   vc_empty;
  logic                   vc_pop;
  logic                   inflight_valid;
  logic [LABEL_WIDTH-1:0] inflight_label;
  logic                   flush_req;
  logic                   flush_done;
  logic                   bus_err;
  logic [31:0]            lines_written;

  victim_wb_ctrl_if #(.BUS_WIDTH(BUS_WIDTH)) bus ();

  victim_wb_ctrl #(.LINE_WIDTH(LINE_WIDTH), .BUS_WIDTH(BUS_WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .vc_rline       (vc_rline),
    .vc_empty       (vc_empty),
    .vc_pop         (vc_pop),
    .bus            (bus),
    .inflight_valid (inflight_valid),
    .inflight_label (inflight_label),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .bus_err        (bus_err),
    .lines_written  (lines_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: cache FIFO contents, line being written, burst progress.
  rline_t     vcq[$];
  logic [1:0] bresp_q[$];
  rline_t     cur;
  bit         busy, aw_done, b_armed;
  int         beats_sent, b_wait, b_delay_max;
  int         exp_lw;
  bit         exp_err;
  int         cyc, pop_cyc, last_line_cycles;
  bit         random_ready, w_toggle, w_phase;
  int         aw_low_cfg, aw_low_left;

  function automatic rline_t rand_line();
    rline_t r = '0;
    for (int i = 0; i < 9; i++) r = (r << 32) | rline_t'($urandom());
    return r;
  endfunction

  task automatic model_reset();
    busy = 0; aw_done = 0; b_armed = 0; beats_sent = 0; b_wait = 0;
    exp_lw = 0; exp_err = 0;
    bresp_q.delete();
  endtask

  task automatic step();
    bit empty, exp_aw, exp_w, exp_b, exp_pop, aw_hs, w_hs, b_hs;
    @(negedge clk);
    cyc++;
    empty        = (vcq.size() == 0);
    vc_empty     = empty;
    vc_rline     = empty ? '0 : vcq[0];
    exp_aw       = busy && !aw_done;
    exp_w        = busy && aw_done && (beats_sent < BEATS);
    exp_b        = busy && (beats_sent == BEATS);
    bus.awready  = random_ready ? ($urandom_range(0, 3) != 0) : (aw_low_left == 0);
    bus.wready   = random_ready ? ($urandom_range(0, 3) != 0) : (w_toggle ? w_phase : 1'b1);
    bus.bvalid   = b_armed && (b_wait == 0);
    bus.bresp    = (bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
    #1;
    exp_pop = !empty && (!busy || (exp_b && bus.bvalid));
    check_eq("vc_pop", vc_pop, exp_pop);
    check_eq("inflight_valid", inflight_valid, busy);
    check_eq("awvalid", bus.awvalid, exp_aw);
    check_eq("wvalid", bus.wvalid, exp_w);
    check_eq("bready", bus.bready, exp_b);
    if (busy) check_eq("inflight_label", inflight_label, cur[LINE_WIDTH +: LABEL_WIDTH]);
    if (exp_aw) begin
      check_eq("awaddr", bus.awaddr, {cur[LINE_WIDTH +: LABEL_WIDTH], 5'b0});
      check_eq("awlen", bus.awlen, BEATS - 1);
    end
    if (exp_w) begin
      check_eq("wdata", bus.wdata, cur[beats_sent*BUS_WIDTH +: BUS_WIDTH]);
      check_eq("wlast", bus.wlast, beats_sent == BEATS - 1);
      check_eq("wstrb", bus.wstrb, 4'hF);
    end
    check_eq("lines_written", lines_written, exp_lw);
    check_eq("bus_err", bus_err, exp_err);
    check_eq("flush_done", flush_done, flush_req && !busy && empty);

    aw_hs = exp_aw && bus.awready;
    w_hs  = exp_w && bus.wready;
    b_hs  = exp_b && bus.bvalid;
    if (exp_aw && !bus.awready && aw_low_left > 0) aw_low_left--;
    if (exp_w) w_phase = !w_phase;
    if (aw_hs) aw_done = 1;
    if (b_hs) begin
      exp_lw++;
      exp_err = exp_err | (bus.bresp != 2'b00);
      if (bresp_q.size() > 0) void'(bresp_q.pop_front());
      b_armed = 0;
      busy    = 0;
      last_line_cycles = cyc - pop_cyc;
    end
    if (b_armed && b_wait > 0) b_wait--;
    if (w_hs) begin
      beats_sent++;
      if (beats_sent == BEATS) begin
        b_armed = 1;
        b_wait  = $urandom_range(0, b_delay_max);
      end
    end
    if (exp_pop) begin
      cur         = vcq.pop_front();
      busy        = 1;
      aw_done     = 0;
      beats_sent  = 0;
      pop_cyc     = cyc;
      aw_low_left = aw_low_cfg;
      w_phase     = 1;
    end
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while ((busy || vcq.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    check_eq("drain_timeout", busy || (vcq.size() != 0), 0);
  endtask

  task automatic set_bus(input bit rnd, input int aw_low, input bit wtog, input int bdly);
    random_ready = rnd; aw_low_cfg = aw_low; w_toggle = wtog; b_delay_max = bdly;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rline_t ln;
    int     n;
    rst = 1'b0; flush_req = 1'b0; vc_empty = 1'b0; vc_rline = rand_line();
    bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    cyc = 0; pop_cyc = 0; last_line_cycles = 0; w_phase = 1; aw_low_left = 0;
    model_reset();
    set_bus(0, 0, 0, 0);

    // Reset values, with a non-empty cache head presented.
    #3;
    check_eq("rst_vc_pop", vc_pop, 0);
    check_eq("rst_awvalid", bus.awvalid, 0);
    check_eq("rst_wvalid", bus.wvalid, 0);
    check_eq("rst_wlast", bus.wlast, 0);
    check_eq("rst_bready", bus.bready, 0);
    check_eq("rst_inflight", inflight_valid, 0);
    check_eq("rst_awaddr", bus.awaddr, 0);
    check_eq("rst_wdata", bus.wdata, 0);
    check_eq("rst_label", inflight_label, 0);
    check_eq("rst_lines", lines_written, 0);
    check_eq("rst_bus_err", bus_err, 0);
    check_eq("rst_wstrb", bus.wstrb, 4'hF);
    check_eq("rst_awlen", bus.awlen, 7);
    flush_req = 1'b1; vc_empty = 1'b1; #1;
    check_eq("rst_flush_done", flush_done, 0);
    flush_req = 1'b0;
    #8 rst = 1'b1;

    // Single line, ready-high bus, bvalid right after wlast.
    ln = '0;
    ln[LINE_WIDTH +: LABEL_WIDTH] = 27'h0000123;
    for (int k = 0; k < BEATS; k++) ln[k*BUS_WIDTH +: BUS_WIDTH] = 32'hA0 + k;
    vcq.push_back(ln);
    run_until_idle(100);
    check_eq("line_time", last_line_cycles, BEATS + 2);
    step();
    check_eq("single_lines", lines_written, 1);

    // Back-to-back: three queued lines.
    for (int i = 0; i < 3; i++) vcq.push_back(rand_line());
    run_until_idle(200);
    step();
    check_eq("b2b_lines", lines_written, 4);

    // Backpressure: awready low three cycles, wready alternating.
    set_bus(0, 3, 1, 0);
    for (int i = 0; i < 2; i++) vcq.push_back(rand_line());
    run_until_idle(200);
    step();
    check_eq("bp_lines", lines_written, 6);

    // Error response on the second of three lines; flag must stay sticky.
    set_bus(0, 0, 0, 0);
    bresp_q.push_back(2'b00); bresp_q.push_back(2'b10); bresp_q.push_back(2'b00);
    for (int i = 0; i < 3; i++) vcq.push_back(rand_line());
    run_until_idle(200);
    step();
    check_eq("err_lines", lines_written, 9);
    check_eq("err_sticky", bus_err, 1);

    // Flush with two lines queued.
    flush_req = 1'b1;
    for (int i = 0; i < 2; i++) vcq.push_back(rand_line());
    run_until_idle(200);
    step();
    check_eq("flush_done_end", flush_done, 1);
    check_eq("flush_lines", lines_written, 11);
    flush_req = 1'b0;

    // Randomized traffic: lines arrive while busy, random ready and response delay.
    set_bus(1, 0, 0, 3);
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 2; i++) begin
        vcq.push_back(rand_line());
        bresp_q.push_back(($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end
      for (int s = 0; s < int'($urandom_range(0, 12)); s++) step();
      for (int i = 0; i < 2; i++) begin
        vcq.push_back(rand_line());
        bresp_q.push_back(2'b00);
      end
      run_until_idle(1000);
      for (int s = 0; s < int'($urandom_range(1, 3)); s++) step();
    end
    check_eq("rand_lines", lines_written, 31);

    // Asynchronous reset in the middle of beat 3.
    set_bus(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) vcq.push_back(rand_line());
    n = 0;
    while (!(busy && aw_done && beats_sent == 3) && n < 100) begin
      step();
      n++;
    end
    check_eq("reach_beat3", beats_sent, 3);
    @(negedge clk); #1;
    check_eq("pre_rst_wvalid", bus.wvalid, 1);
    #1 rst = 1'b0;
    #1;
    check_eq("async_wvalid", bus.wvalid, 0);
    check_eq("async_inflight", inflight_valid, 0);
    check_eq("async_lines", lines_written, 0);
    model_reset();
    vc_empty = 1'b1; bus.bvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    run_until_idle(200);
    step();
    check_eq("post_rst_lines", lines_written, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/victim_wb_ctrl.md
# victim_wb_ctrl

Write-back drain controller for the victim cache. It sits between the victim cache FIFO port and the memory write bus. It pops one evicted line at a time, latches it, and emits it as a single burst write (address phase, LINE_WIDTH/BUS_WIDTH data beats, response). While a line is in flight it exports that line's label, so the cache can stall refills that would otherwise read stale memory.

## Interface
- LINE_WIDTH, 256, cache line width in bits; same value as the victim cache.
- BUS_WIDTH, 32, write-data beat width in bits; divides LINE_WIDTH.
- Derived: BEATS = LINE_WIDTH/BUS_WIDTH; LINE_BYTE_OFFSET = clog2(LINE_WIDTH/8); LABEL_WIDTH = 32 - LINE_BYTE_OFFSET (phys_t is 32 bits).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-low.
- vc_rline  in  LABEL_WIDTH+LINE_WIDTH  victim cache head line; label in the MSBs, data in the LSBs.
- vc_empty  in  1  victim cache empty.
- vc_pop  out  1  pop the victim cache head this cycle.
- awaddr  out  32  burst address = {label, LINE_BYTE_OFFSET'b0}.
- awlen  out  8  constant BEATS-1.
- awvalid / awready  out / in  1  address handshake.
- wdata  out  BUS_WIDTH  current beat.
- wstrb  out  BUS_WIDTH/8  all ones.
- wlast  out  1  final beat.
- wvalid / wready  out / in  1  data handshake.
- bresp  in  2  write response code.
- bvalid / bready  in / out  1  response handshake.
- inflight_valid  out  1  a latched line has not yet been acknowledged by the bus.
- inflight_label  out  LABEL_WIDTH  label of the in-flight line.
- flush_req  in  1  level request: drain the victim cache to memory.
- flush_done  out  1  flush complete.
- bus_err  out  1  sticky flag: some bresp was non-zero.
- lines_written  out  32  count of acknowledged lines; wraps.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - vc_pop = ~vc_empty, combinational.
  - On a pop, latch vc_rline into the line buffer, clear the beat counter, and go to ADDR.
- ADDR:
  - awvalid = 1.
  - On awvalid & awready, go to DATA.
- DATA:
  - wvalid = 1; wdata = line data bits [beat*BUS_WIDTH +: BUS_WIDTH], lowest beat first.
  - wlast = (beat == BEATS-1).
  - Each wvalid & wready increments beat.
  - The handshake on the last beat goes to RESP.
- RESP:
  - bready = 1.
  - On bvalid: lines_written += 1, and bus_err |= (bresp != 0).
  - Then: if ~vc_empty, pop again, latch, and go to ADDR (back-to-back, no IDLE bubble). Otherwise go to IDLE.
- AW and W never overlap; W starts only after the AW handshake.
- inflight_valid is 1 in ADDR, DATA and RESP, and 0 in IDLE. inflight_label holds the latched label.
- flush_done = flush_req & state==IDLE & vc_empty, combinational. Draining is unconditional, so flush_req only qualifies done.
- Stalls:
  - awready or wready low holds all outputs stable.
  - No valid is withdrawn once asserted before its handshake completes.

## Timing
- Reset values:
  - FSM = IDLE.
  - vc_pop, awvalid, wvalid, wlast, bready, inflight_valid, flush_done, bus_err = 0.
  - awaddr, wdata, inflight_label, lines_written = 0.
  - wstrb = all ones; awlen = BEATS-1 (constants).
- Pop edge to awvalid: 1 cycle.
- Minimum line time with ready-high bus and bvalid one cycle after wlast: 1 (ADDR) + BEATS (DATA) + 1 (RESP) = BEATS+2 cycles.
- Back-to-back throughput: one line per BEATS+2 cycles.
- Pop is never asserted while vc_empty.
- Reset asserted mid-burst:
  - Immediate return to IDLE, all outputs go to their reset values.
  - The latched line is discarded; the system resets as a whole.
- lines_written wraps from 0xFFFF_FFFF to 0.

## Structure
- Shared cache package holds phys_t, uint8_t, LINE_BYTE_OFFSET/LABEL_WIDTH helpers, and the wb_state_t enum {IDLE, ADDR, DATA, RESP}.
- Single module; the beat serializer (line buffer plus beat counter) is inline.
- Target: roughly 150-250 lines of RTL.

## Test plan
- Single line, ready-high bus, bvalid in the cycle after wlast:
  - Stimulus: label 27'h0000123, data word k = 32'hA0+k, bresp=0.
  - Required: awaddr=32'h00002460, awlen=7; 8 beats 0xA0..0xA7 with wlast on beat 7; lines_written=1; total 10 cycles from pop.
- Back-to-back: three lines queued.
  - Required: vc_pop in IDLE and then in RESP on the bvalid cycles; no IDLE between lines; lines_written=3; inflight_valid never drops between lines.
- Backpressure: awready low for 3 cycles, wready toggling 1/0 on each beat.
  - Required: awaddr/wdata/wlast stable while not ready; every beat delivered exactly once, in order.
- Error response: bresp=2'b10 on the second line.
  - Required: bus_err=1 after that cycle and still 1 after a later OKAY; lines_written still increments.
- Flush: flush_req=1 with two lines queued.
  - Required: flush_done=0 until the second bvalid, then 1 in the IDLE cycle with vc_empty.
- Async reset low in the middle of DATA beat 3.
  - Required: wvalid and inflight_valid fall without a clock edge; after release, FSM is in IDLE and the next queued line restarts cleanly at beat 0.
